// File: rtl/mult_share_pkg.sv
// Purpose : shared constants for the multiplier-sharing arbiter (FSM encoding, counter sizing).
// Latency : n/a (package only).
// Backpressure: n/a.
package mult_share_pkg;

  // FSM encoding, kept as plain 2-bit constants for compatibility with older tooling.
  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ISSUE = 2'd1;
  localparam logic [1:0] DONE  = 2'd2;

  // Width of the ISSUE-cycle counter: it must be able to hold the timeout value itself.
  function automatic int cnt_width(input int timeout_cycles);
    return $clog2(timeout_cycles + 1);
  endfunction

endpackage

// File: rtl/rr_arbiter_onehot.sv
// Purpose : round-robin pick of the first set request strictly after ptr (wrapping).
// Latency : combinational.
// Backpressure: none; the caller decides when the pick is consumed.
// Ports   : req (request levels), ptr (last winner) -> gnt (one-hot), idx (binary), any (some req set).
module rr_arbiter_onehot #(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] gnt,
  output logic [IDX_W-1:0]   idx,
  output logic               any
);

  int               pos;
  logic [IDX_W-1:0] pidx;

  // Walk offsets 1..NUM_REQ from the pointer; the last offset is the pointer itself,
  // so the previous winner only wins again when nobody else is asking.
  always_comb begin
    gnt  = '0;
    idx  = '0;
    any  = 1'b0;
    pos  = 0;
    pidx = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      pos = int'(ptr) + k;
      if (pos >= NUM_REQ) pos = pos - NUM_REQ;
      pidx = IDX_W'(pos);
      if (!any && req[pidx]) begin
        any       = 1'b1;
        gnt[pidx] = 1'b1;
        idx       = pidx;
      end
    end
  end

endmodule

// File: rtl/mult_share_arbiter.sv
// Purpose : shares one start/ready multiplier among NUM_REQ requesters with round-robin grant.
// Latency : done 3 cycles after req is sampled in IDLE; 1 for a zero operand; TIMEOUT_CYCLES+1 on timeout.
// Backpressure: requesters hold req until their done pulse; others simply wait for grant.
// Ports   : req/a_flat/b_flat in, grant/done/result/err/busy out; mul_* drive/observe the multiplier.
module mult_share_arbiter
  import mult_share_pkg::*;
#(
  parameter int DATA_WIDTH     = 32,
  parameter int NUM_REQ        = 4,
  parameter int TIMEOUT_CYCLES = 15
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [NUM_REQ-1:0]            req,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] a_flat,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] b_flat,
  output logic [NUM_REQ-1:0]            grant,
  output logic [NUM_REQ-1:0]            done,
  output logic [2*DATA_WIDTH-1:0]       result,
  output logic                          err,
  output logic                          busy,
  output logic                          mul_start,
  output logic [DATA_WIDTH-1:0]         mul_multiplier,
  output logic [DATA_WIDTH-1:0]         mul_multiplicand,
  input  logic [2*DATA_WIDTH-1:0]       mul_product,
  input  logic                          mul_ready
);

  localparam int               IDX_W    = $clog2(NUM_REQ);
  localparam int               CNT_W    = cnt_width(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES);

  logic [1:0]            state;
  logic [IDX_W-1:0]      ptr;
  logic [CNT_W-1:0]      cnt;
  logic [DATA_WIDTH-1:0] op_a;
  logic [DATA_WIDTH-1:0] op_b;
  logic [DATA_WIDTH-1:0] sel_a;
  logic [DATA_WIDTH-1:0] sel_b;
  logic [NUM_REQ-1:0]    arb_gnt;
  logic [IDX_W-1:0]      arb_idx;
  logic                  arb_any;

  rr_arbiter_onehot #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_rr (
    .req (req),
    .ptr (ptr),
    .gnt (arb_gnt),
    .idx (arb_idx),
    .any (arb_any)
  );

  // One-hot mux of the winner's operands.
  always_comb begin
    sel_a = '0;
    sel_b = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (arb_gnt[i]) begin
        sel_a = sel_a | a_flat[i*DATA_WIDTH +: DATA_WIDTH];
        sel_b = sel_b | b_flat[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  // Outputs derived straight from registered state so an async reset clears them at once.
  assign busy             = (state != IDLE);
  assign mul_start        = (state == ISSUE);
  assign mul_multiplier   = op_a;
  assign mul_multiplicand = op_b;
  assign done             = (state == DONE) ? grant : '0;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state  <= IDLE;
      ptr    <= IDX_W'(NUM_REQ - 1);
      cnt    <= '0;
      op_a   <= '0;
      op_b   <= '0;
      grant  <= '0;
      result <= '0;
      err    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (arb_any) begin
            grant <= arb_gnt;
            ptr   <= arb_idx;
            op_a  <= sel_a;
            op_b  <= sel_b;
            cnt   <= CNT_ONE;
            err   <= 1'b0;
            // The multiplier never answers a zero operand, so answer it here.
            if (sel_a == '0 || sel_b == '0) begin
              result <= '0;
              state  <= DONE;
            end else begin
              state <= ISSUE;
            end
          end
        end
        ISSUE: begin
          // cnt==1 is the first ISSUE cycle: mul_ready may still reflect a stale value.
          if (cnt != CNT_ONE && mul_ready) begin
            result <= mul_product;
            state  <= DONE;
          end else if (cnt == CNT_LAST) begin
            result <= '0;
            err    <= 1'b1;
            state  <= DONE;
          end else begin
            cnt <= cnt + CNT_ONE;
          end
        end
        DONE: begin
          state <= IDLE;
          grant <= '0;
          err   <= 1'b0;
        end
        default: begin
          state <= IDLE;
          grant <= '0;
          err   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mult_share_arbiter.sv
// Purpose : self-checking bench for mult_share_arbiter with a registered start/ready multiplier model.
// Latency : n/a.
// Backpressure: n/a.
module tb_mult_share_arbiter;

  localparam int W  = 32;
  localparam int N  = 4;
  localparam int TO = 15;
  localparam int IW = $clog2(N);

  logic             clk = 1'b0;
  logic             reset;
  logic [N-1:0]     req;
  logic [N*W-1:0]   a_flat, b_flat;
  logic [N-1:0]     grant, done;
  logic [2*W-1:0]   result;
  logic             err, busy, mul_start;
  logic [W-1:0]     mul_multiplier, mul_multiplicand;
  logic [2*W-1:0]   mul_product;
  logic             mul_ready;
  logic             stuck;

  int checks = 0;
  int errors = 0;
  int mptr;

  mult_share_arbiter #(.DATA_WIDTH(W), .NUM_REQ(N), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .reset(reset), .req(req), .a_flat(a_flat), .b_flat(b_flat),
    .grant(grant), .done(done), .result(result), .err(err), .busy(busy),
    .mul_start(mul_start), .mul_multiplier(mul_multiplier), .mul_multiplicand(mul_multiplicand),
    .mul_product(mul_product), .mul_ready(mul_ready)
  );

  always #5 clk = ~clk;

  // Multiplier model: registered product, ready one cycle after start, silent on zero operands.
  always @(posedge clk) begin
    mul_ready   <= mul_start && !stuck && (mul_multiplier != 0) && (mul_multiplicand != 0);
    mul_product <= {{W{1'b0}}, mul_multiplier} * {{W{1'b0}}, mul_multiplicand};
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  // Reference: first requester after the last winner, wrapping around.
  function automatic int winner(input logic [N-1:0] r, input int p);
    for (int k = 1; k <= N; k++)
      if (r[IW'((p + k) % N)]) return (p + k) % N;
    return -1;
  endfunction

  task automatic set_op(input int i, input logic [W-1:0] a, input logic [W-1:0] b);
    a_flat[i*W +: W] = a;
    b_flat[i*W +: W] = b;
  endtask

  task automatic wait_done(input int budget, output int lat);
    lat = 0;
    for (int c = 1; c <= budget; c++) begin
      @(negedge clk);
      if (done != '0) begin
        lat = c;
        break;
      end
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0;
    req   = '0;
    @(negedge clk);
    reset = 1'b1;
    mptr  = N - 1;
  endtask

  task automatic test_reset();
    reset = 1'b0; req = '0; a_flat = '0; b_flat = '0; stuck = 1'b0;
    repeat (2) @(negedge clk);
    checks++; if (grant !== 4'b0)     begin errors++; $display("FAIL reset_grant got %b want 0", grant); end
    checks++; if (done !== 4'b0)      begin errors++; $display("FAIL reset_done got %b want 0", done); end
    checks++; if (busy !== 1'b0)      begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
    checks++; if (mul_start !== 1'b0) begin errors++; $display("FAIL reset_start got %b want 0", mul_start); end
    checks++; if (result !== 64'd0)   begin errors++; $display("FAIL reset_result got %h want 0", result); end
    checks++; if (err !== 1'b0)       begin errors++; $display("FAIL reset_err got %b want 0", err); end
    reset = 1'b1;
    mptr  = N - 1;
  endtask

  task automatic test_single();
    logic [2*W-1:0] exp;
    exp = 64'(32'd3) * 64'(32'd5);
    req = 4'b0001; set_op(0, 3, 5);
    @(negedge clk); // cycle 1
    checks++; if (grant !== 4'b0001)  begin errors++; $display("FAIL single_grant got %b want 0001", grant); end
    checks++; if (mul_start !== 1'b1) begin errors++; $display("FAIL single_start1 got %b want 1", mul_start); end
    checks++; if (mul_multiplier !== 32'd3) begin errors++; $display("FAIL single_opa got %0d want 3", mul_multiplier); end
    set_op(0, 100, 100); // must be ignored: operands were latched at grant
    @(negedge clk); // cycle 2
    checks++; if (mul_start !== 1'b1) begin errors++; $display("FAIL single_start2 got %b want 1", mul_start); end
    checks++; if (done !== 4'b0)      begin errors++; $display("FAIL single_early_done got %b want 0", done); end
    @(negedge clk); // cycle 3
    checks++; if (done !== 4'b0001)   begin errors++; $display("FAIL single_done got %b want 0001", done); end
    checks++; if (result !== exp)     begin errors++; $display("FAIL single_result got %0d want %0d", result, exp); end
    checks++; if (err !== 1'b0)       begin errors++; $display("FAIL single_err got %b want 0", err); end
    checks++; if (mul_start !== 1'b0) begin errors++; $display("FAIL single_start3 got %b want 0", mul_start); end
    req = '0;
    @(negedge clk); // cycle 4
    checks++; if (done !== 4'b0)      begin errors++; $display("FAIL single_done_width got %b want 0", done); end
    checks++; if (grant !== 4'b0)     begin errors++; $display("FAIL single_grant_clear got %b want 0", grant); end
    checks++; if (busy !== 1'b0)      begin errors++; $display("FAIL single_busy got %b want 0", busy); end
    mptr = 0;
  endtask

  task automatic test_full_load();
    int order [5] = '{0, 1, 2, 3, 0};
    int lat, w;
    do_reset();
    for (int i = 0; i < N; i++) set_op(i, 2, 7);
    req = 4'b1111;
    for (int n = 0; n < 5; n++) begin
      w = winner(req, mptr);
      wait_done(12, lat);
      checks++; if (lat !== ((n == 0) ? 3 : 4)) begin errors++; $display("FAIL full_lat[%0d] got %0d want %0d", n, lat, (n == 0) ? 3 : 4); end
      checks++; if (done !== (N'(1) << order[n])) begin errors++; $display("FAIL full_order[%0d] got %b want %b", n, done, N'(1) << order[n]); end
      checks++; if (w !== order[n])   begin errors++; $display("FAIL full_model[%0d] got %0d want %0d", n, w, order[n]); end
      checks++; if (result !== 64'd14) begin errors++; $display("FAIL full_result[%0d] got %0d want 14", n, result); end
      checks++; if (err !== 1'b0)      begin errors++; $display("FAIL full_err[%0d] got %b want 0", n, err); end
      mptr = w;
    end
    req = '0;
    @(negedge clk);
  endtask

  task automatic test_zero_bypass();
    req = 4'b0100; set_op(2, 0, 9);
    @(negedge clk); // cycle 1
    checks++; if (done !== 4'b0100)   begin errors++; $display("FAIL zero_done got %b want 0100", done); end
    checks++; if (result !== 64'd0)   begin errors++; $display("FAIL zero_result got %0d want 0", result); end
    checks++; if (mul_start !== 1'b0) begin errors++; $display("FAIL zero_start1 got %b want 0", mul_start); end
    req = '0;
    @(negedge clk);
    checks++; if (mul_start !== 1'b0) begin errors++; $display("FAIL zero_start2 got %b want 0", mul_start); end
    mptr = 2;
  endtask

  task automatic test_timeout();
    stuck = 1'b1;
    req = 4'b0010; set_op(1, 5, 6);
    for (int c = 1; c <= TO; c++) begin
      @(negedge clk);
      checks++; if (mul_start !== 1'b1 || done !== 4'b0) begin errors++; $display("FAIL timeout_wait c%0d start %b done %b want 1/0000", c, mul_start, done); end
    end
    @(negedge clk); // cycle TO+1
    checks++; if (done !== 4'b0010)  begin errors++; $display("FAIL timeout_done got %b want 0010", done); end
    checks++; if (err !== 1'b1)      begin errors++; $display("FAIL timeout_err got %b want 1", err); end
    checks++; if (result !== 64'd0)  begin errors++; $display("FAIL timeout_result got %0d want 0", result); end
    req = '0; stuck = 1'b0;
    @(negedge clk);
    checks++; if (err !== 1'b0)      begin errors++; $display("FAIL timeout_err_clear got %b want 0", err); end
    mptr = 1;
  endtask

  task automatic test_max();
    int lat;
    req = 4'b1000; set_op(3, 32'hFFFFFFFF, 32'hFFFFFFFF);
    wait_done(6, lat);
    checks++; if (lat !== 3)          begin errors++; $display("FAIL max_lat got %0d want 3", lat); end
    checks++; if (done !== 4'b1000)   begin errors++; $display("FAIL max_done got %b want 1000", done); end
    checks++; if (result !== 64'hFFFFFFFE00000001) begin errors++; $display("FAIL max_result got %h want fffffffe00000001", result); end
    req = '0;
    @(negedge clk);
    mptr = 3;
  endtask

  task automatic test_reset_mid();
    int lat, seen;
    req = 4'b0001; set_op(0, 4, 4);
    @(negedge clk); // cycle 1, in ISSUE
    checks++; if (mul_start !== 1'b1) begin errors++; $display("FAIL rmid_pre_start got %b want 1", mul_start); end
    reset = 1'b0;
    #1;
    checks++; if (busy !== 1'b0)      begin errors++; $display("FAIL rmid_busy got %b want 0", busy); end
    checks++; if (grant !== 4'b0)     begin errors++; $display("FAIL rmid_grant got %b want 0", grant); end
    checks++; if (mul_start !== 1'b0) begin errors++; $display("FAIL rmid_start got %b want 0", mul_start); end
    seen = 0;
    repeat (3) begin @(negedge clk); if (done != '0) seen++; end
    req = '0; reset = 1'b1; mptr = N - 1;
    repeat (2) begin @(negedge clk); if (done != '0) seen++; end
    checks++; if (seen !== 0)         begin errors++; $display("FAIL rmid_no_done got %0d pulses want 0", seen); end
    req = 4'b0010; set_op(1, 6, 7);
    wait_done(6, lat);
    checks++; if (lat !== 3)          begin errors++; $display("FAIL rmid_next_lat got %0d want 3", lat); end
    checks++; if (done !== 4'b0010)   begin errors++; $display("FAIL rmid_next_done got %b want 0010", done); end
    checks++; if (result !== 64'd42)  begin errors++; $display("FAIL rmid_next_result got %0d want 42", result); end
    req = '0;
    @(negedge clk);
    mptr = 1;
  endtask

  task automatic test_random();
    logic [W-1:0]   ta [N];
    logic [W-1:0]   tbv [N];
    logic [N-1:0]   r;
    logic [2*W-1:0] exp;
    int w, lat, exp_lat;
    bit zero;
    for (int it = 0; it < 30; it++) begin
      r = N'($urandom_range(1, (1 << N) - 1));
      for (int i = 0; i < N; i++) begin
        ta[i]  = ($urandom_range(0, 4) == 0) ? '0 : W'($urandom);
        tbv[i] = ($urandom_range(0, 4) == 0) ? '0 : W'($urandom);
        set_op(i, ta[i], tbv[i]);
      end
      w       = winner(r, mptr);
      zero    = (ta[w] == 0) || (tbv[w] == 0);
      exp     = zero ? 64'd0 : 64'(ta[w]) * 64'(tbv[w]);
      exp_lat = zero ? 1 : 3;
      req = r;
      @(negedge clk); // cycle 1
      checks++; if (grant !== (N'(1) << w)) begin errors++; $display("FAIL rand%0d_grant got %b want %b", it, grant, N'(1) << w); end
      if (done != '0) lat = 1;
      else begin
        // Late operand edits and dropped requests must not disturb the operation.
        if ($urandom_range(0, 1) == 1) begin
          req = '0;
          for (int i = 0; i < N; i++) set_op(i, W'($urandom), W'($urandom));
        end
        wait_done(TO + 2, lat);
        if (lat != 0) lat = lat + 1;
      end
      checks++; if (lat !== exp_lat)        begin errors++; $display("FAIL rand%0d_lat got %0d want %0d", it, lat, exp_lat); end
      checks++; if (done !== (N'(1) << w))  begin errors++; $display("FAIL rand%0d_done got %b want %b", it, done, N'(1) << w); end
      checks++; if (result !== exp)         begin errors++; $display("FAIL rand%0d_result got %h want %h", it, result, exp); end
      checks++; if (err !== 1'b0)           begin errors++; $display("FAIL rand%0d_err got %b want 0", it, err); end
      mptr = w;
      req = '0;
      @(negedge clk);
    end
  endtask

  initial begin
    test_reset();
    @(negedge clk);
    test_single();
    test_full_load();
    test_zero_bypass();
    test_timeout();
    test_max();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
